// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory block responder: block geometry,
// FSM state encoding and byte-address to word-index mapping.
package dmem_pkg;

  localparam int BLOCK_WORDS = 4;
  localparam int WORD_BITS   = 32;
  localparam int BLOCK_BITS  = BLOCK_WORDS * WORD_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Drops the byte offset and wraps modulo the (power-of-2) storage depth.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned depth_words);
    return (addr >> 2) & (depth_words - 1);
  endfunction

endpackage

// File: rtl/dmem_block_responder_if.sv
// Request/response bundle between the cache controller (master) and the
// memory-side block responder (slave).
interface dmem_block_responder_if
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                              req_valid;
  logic                              req_ready;
  logic                              req_write;
  logic [ADDR_WIDTH-1:0]             req_addr;
  logic [DATA_WIDTH-1:0]             req_wdata;
  logic                              resp_valid;
  logic                              resp_ready;
  logic                              resp_write;
  logic [DATA_WIDTH*BLOCK_WORDS-1:0] resp_block;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_write, resp_block
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_write, resp_block
  );

endinterface

// File: rtl/dmem_word_array.sv
// Backing word storage: one synchronous write port and a combinational
// four-word block read. Contents are deliberately not reset.
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic [$clog2(DEPTH_WORDS)-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0]              wdata,
  input  logic [$clog2(DEPTH_WORDS)-3:0]     rblk,
  output logic [DATA_WIDTH*BLOCK_WORDS-1:0]  rblock
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_rd
      assign rblock[gi*DATA_WIDTH +: DATA_WIDTH] = mem[{rblk, 2'(gi)}];
    end
  endgenerate

endmodule

// File: rtl/dmem_block_responder.sv
// Fixed-latency memory responder: block reads, single-word writes.
// Optional access counters are enabled with `define DMEM_ACCESS_CNT_EN.
module dmem_block_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  dmem_block_responder_if.slave  bus
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
`endif
);

  localparam int IDX_BITS = $clog2(DEPTH_WORDS);
  localparam int BLOCK_W  = DATA_WIDTH * WORDS_PER_BLOCK;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]            state_reg;
  logic [3:0]            cnt_reg;
  logic                  write_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  req_ready_reg;
  logic                  resp_valid_reg;
  logic                  resp_write_reg;
  logic [BLOCK_W-1:0]    resp_block_reg;

  logic [IDX_BITS-1:0]   word_idx;
  logic [BLOCK_W-1:0]    rd_block;
  logic                  wait_done;
  logic                  mem_we;

  assign word_idx  = IDX_BITS'(word_index(32'(addr_reg), DEPTH_WORDS));
  assign wait_done = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
  // Gated by reset so a write caught in WAIT never reaches storage.
  assign mem_we    = wait_done && write_reg && !reset;

  dmem_word_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (word_idx),
    .wdata  (wdata_reg),
    .rblk   (word_idx[IDX_BITS-1:2]),
    .rblock (rd_block)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 4'd0;
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_write_reg <= 1'b0;
      resp_block_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.req_valid) begin
            write_reg     <= bus.req_write;
            addr_reg      <= bus.req_addr;
            wdata_reg     <= bus.req_wdata;
            cnt_reg       <= 4'(LATENCY - 1);
            req_ready_reg <= 1'b0;
            state_reg     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            if (!write_reg) begin
              resp_block_reg <= rd_block;
            end
            resp_write_reg <= write_reg;
            resp_valid_reg <= 1'b1;
            state_reg      <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
            state_reg      <= ST_IDLE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_write = resp_write_reg;
  assign bus.resp_block = resp_block_reg;

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rd_count_reg;
  logic [31:0] wr_count_reg;

  // Saturating: counts stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count_reg <= 32'd0;
      wr_count_reg <= 32'd0;
    end else if (wait_done) begin
      if (write_reg) begin
        if (wr_count_reg != 32'hFFFF_FFFF) begin
          wr_count_reg <= wr_count_reg + 32'd1;
        end
      end else begin
        if (rd_count_reg != 32'hFFFF_FFFF) begin
          rd_count_reg <= rd_count_reg + 32'd1;
        end
      end
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
`endif

endmodule
